// File: rtl/i2c_slave_bmp.sv
// I2C slave exposing a small BMP-style register map (chip id, calibration RAM,
// control register, measurement registers) behind an auto-incrementing pointer.
module i2c_slave_bmp #(
  parameter logic [6:0] ADR     = 7'h77,
  parameter logic [7:0] CHIP_ID = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [23:0] meas_data,
  input  logic        meas_load,
  output logic [7:0]  ctrl_out,
  output logic        ctrl_wr,
  output logic        busy
);

  localparam int unsigned CAL_N = 22;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BITS = CNT_W'(8);
  localparam logic [7:0] A_ID     = 8'hD0;
  localparam logic [7:0] A_CAL_LO = 8'hAA;
  localparam logic [7:0] A_CAL_HI = 8'hBF;
  localparam logic [7:0] A_CTRL   = 8'hF4;
  localparam logic [7:0] A_M0     = 8'hF6;
  localparam logic [7:0] A_M1     = 8'hF7;
  localparam logic [7:0] A_M2     = 8'hF8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t           state, state_n;
  logic [1:0]       scl_sync, sda_sync;
  logic             scl_q, sda_q;
  logic [1:0]       settle;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       ptr, ptr_n;
  logic             rw, rw_n;
  logic             oe_n, busy_n;
  logic             wr_en;
  logic [7:0]       cal [CAL_N];
  logic [23:0]      meas;
  logic [7:0]       rd_byte;
  logic [4:0]       cal_idx;
  logic             in_cal;
  logic             scl_s, sda_s, armed;
  logic             scl_rise, scl_fall, start, stop;

  // Two-flop synchronizers plus previous-value flops; edges are gated until the chain has settled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      settle   <= 2'd0;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
      settle   <= (settle == 2'd3) ? settle : settle + 2'd1;
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign armed    = (settle == 2'd3);
  assign scl_rise = armed & scl_s & ~scl_q;
  assign scl_fall = armed & ~scl_s & scl_q;
  assign start    = armed & scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = armed & scl_s & scl_q & ~sda_q & sda_s;

  assign in_cal  = (ptr >= A_CAL_LO) && (ptr <= A_CAL_HI);
  assign cal_idx = 5'(ptr - A_CAL_LO);

  // Register map read mux at the current pointer
  always_comb begin
    rd_byte = 8'h00;
    if (ptr == A_ID)        rd_byte = CHIP_ID;
    else if (in_cal)        rd_byte = cal[cal_idx];
    else if (ptr == A_CTRL) rd_byte = ctrl_out;
    else if (ptr == A_M0)   rd_byte = meas[23:16];
    else if (ptr == A_M1)   rd_byte = meas[15:8];
    else if (ptr == A_M2)   rd_byte = meas[7:0];
  end

  // Protocol state register and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shift  <= '0;
      ptr    <= '0;
      rw     <= 1'b0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shift  <= shift_n;
      ptr    <= ptr_n;
      rw     <= rw_n;
      sda_oe <= oe_n;
      busy   <= busy_n;
    end
  end

  // Next-state logic; STOP and START override whatever byte is in flight
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    ptr_n   = ptr;
    rw_n    = rw;
    oe_n    = sda_oe;
    busy_n  = busy;
    wr_en   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR, REG, WDATA: begin
          if (scl_rise && cnt != BITS) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + CNT_W'(1);
          end else if (scl_fall && cnt == BITS) begin
            cnt_n = '0;
            if (state == ADDR) begin
              if (shift[7:1] == ADR) begin
                state_n = ADDR_ACK;
                oe_n    = 1'b1;
                busy_n  = 1'b1;
                rw_n    = shift[0];
              end else begin
                state_n = IDLE;
              end
            end else if (state == REG) begin
              ptr_n   = shift;
              state_n = REG_ACK;
              oe_n    = 1'b1;
            end else begin
              wr_en   = 1'b1;
              state_n = WDATA_ACK;
              oe_n    = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = '0;
            if (rw) begin
              state_n = RDATA;
              shift_n = rd_byte;
              oe_n    = ~rd_byte[7];
            end else begin
              state_n = REG;
              oe_n    = 1'b0;
            end
          end
        end
        REG_ACK: begin
          if (scl_fall) begin
            state_n = WDATA;
            oe_n    = 1'b0;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            state_n = WDATA;
            oe_n    = 1'b0;
            ptr_n   = ptr + 8'd1;
          end
        end
        RDATA: begin
          if (scl_rise && cnt != BITS) begin
            cnt_n = cnt + CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt == BITS) begin
              state_n = RDATA_ACK;
              oe_n    = 1'b0;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              oe_n    = ~shift[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr + 8'd1;
            if (sda_s) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall) begin
            state_n = RDATA;
            cnt_n   = '0;
            shift_n = rd_byte;
            oe_n    = ~rd_byte[7];
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Writable registers, measurement latch and control-write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cal      <= '{default: 8'h00};
      ctrl_out <= 8'h00;
      ctrl_wr  <= 1'b0;
      meas     <= 24'h000000;
    end else begin
      ctrl_wr <= 1'b0;
      if (meas_load) meas <= meas_data;
      if (wr_en && in_cal) cal[cal_idx] <= shift;
      if (wr_en && ptr == A_CTRL) begin
        ctrl_out <= shift;
        ctrl_wr  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/i2c_slave_bmp.md
I2C_SLAVE_BMP -- requirements
Module: i2c_slave_bmp

Interface
REQ-001 SHALL have parameter ADR, default 7'h77, the 7-bit I2C device address it answers.
REQ-002 SHALL have parameter CHIP_ID, default 8'h55, the value returned from register 0xD0.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 scl  input  1  I2C clock from the bus master (asynchronous to clk).
REQ-006 sda_in  input  1  sampled SDA line level (asynchronous to clk).
REQ-007 sda_oe  output  1  1 = pull SDA low; 0 = release the line (open-drain).
REQ-008 meas_data  input  24  measurement value for registers F6 (bits 23:16), F7 (bits 15:8) and F8 (bits 7:0).
REQ-009 meas_load  input  1  one-clk strobe that latches meas_data into the F6..F8 registers.
REQ-010 ctrl_out  output  8  current value of register 0xF4.
REQ-011 ctrl_wr  output  1  one-clk pulse after each bus write to 0xF4.
REQ-012 busy  output  1  high from an address match until STOP, START or NACK.

Function
REQ-013 scl and sda_in SHALL each pass through a 2-flop synchronizer; the block SHALL detect edges from the synchronized signals only.
REQ-014 START: synced SDA falls while synced SCL is high; STOP: synced SDA rises while synced SCL is high. Both SHALL be recognised in every state, and START SHALL take priority over the current operation.
REQ-015 Data bits SHALL be sampled on a synced SCL rising edge. SDA SHALL change only within 1 clk after a synced SCL falling edge.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 IDLE: START -> ADDR with bit counter cleared; any other SCL activity is ignored.
REQ-018 ADDR: shift 8 bits MSB first. If bits[7:1]==ADR, go to ADDR_ACK and drive ACK. On mismatch, keep sda_oe=0 and go to IDLE.
REQ-019 ACK timing: sda_oe=1 from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
REQ-020 After ADDR_ACK: R/W=0 -> REG; R/W=1 -> RDATA. In RDATA the first bit SHALL be presented at the ACK-ending falling edge.
REQ-021 REG: the received byte SHALL load the register pointer, then the FSM SHALL go to REG_ACK (ACK) and then WDATA.
REQ-022 WDATA: the received byte SHALL be written at the pointer, then ACK, then the pointer SHALL increment, repeating until STOP or START.
REQ-023 RDATA: the byte at the pointer SHALL be loaded into the shift register at its first bit. The block SHALL drive sda_oe=~bit, MSB first, for 8 bits.
REQ-024 RDATA_ACK: the block SHALL release SDA and sample the master's bit, then increment the pointer. ACK(0) -> RDATA with the next byte; NACK(1) -> IDLE with busy=0.
REQ-025 Register map:
  - 0xD0: CHIP_ID, read-only.
  - 0xAA..0xBF: 22-byte R/W calibration RAM.
  - 0xF4: R/W control register.
  - 0xF6..0xF8: read-only measurement registers.
  - All other addresses: read 0x00, writes ignored.
REQ-026 The pointer SHALL be 8 bits and wrap 0xFF -> 0x00.
REQ-027 Repeated START after the REG phase SHALL retain the pointer, giving write-pointer-then-read.
REQ-028 STOP in any state SHALL force IDLE, sda_oe=0 and busy=0.
REQ-029 meas_load coincident with a read of F6..F8: a byte already in the shift register SHALL be unaffected; later bytes SHALL return the new value.
REQ-030 sda_oe SHALL never be 1 outside ACK slots and RDATA bit slots.

Reset
REQ-031 On reset=0, asynchronously:
  - state=IDLE, pointer=0, shift/bit counters=0
  - sda_oe=0, busy=0, ctrl_wr=0
  - ctrl_out=0x00, calibration RAM=0x00, measurement regs=0x000000
REQ-032 Reset asserted mid-transaction SHALL release SDA immediately. After reset release, the block SHALL ignore the bus until the next START.

Verification
REQ-033 START, 0xEE, 0xD0, Sr, 0xEF, read 1 byte with NACK, STOP -> three ACKs driven, byte 0x55 read, busy=0 after the NACK.
REQ-034 Write 0xEE, 0xF4, 0x2E -> ctrl_out=0x2E and one ctrl_wr pulse; a read-back of 0xF4 returns 0x2E.
REQ-035 meas_load with 0x123456, then a 3-byte read from 0xF6 with ACK, ACK, NACK -> bytes 0x12, 0x34, 0x56.
REQ-036 Write 0xEE, 0xFF, 0xA1, 0xB2 -> pointer wraps: address 0xFF write is ignored, address 0x00 write is ignored, and a read of 0xAA returns 0x00.
REQ-037 Address 0xEC (wrong address) -> sda_oe stays 0 for the whole transfer, busy stays 0.
REQ-038 reset=0 during RDATA bit 3 -> sda_oe=0 within the same clk; a following valid transaction completes normally.
